uart_cmd_frame_parser: RTL and testbench
========================================

// Module: uart_cmd_frame_parser
// PURPOSE
//  Parametrised UART command-frame parser for the MxV accelerator. Consumes received bytes and
//  validates frames: 0xFE, LEN, CMD, payload, 0xEF. Commits N only on a fully valid frame.
//  Issues a command strobe, then holds BUSY until the datapath acknowledges.
//  Sits between the UART RX and the MxV control and datapath.
// PARAMETERS
//  DATA_W       8      byte width of rx_data / payload_data
//  MAX_N        8      largest legal N argument for CMD_SET_N
//  MAX_LEN      16     largest legal LEN byte (LEN = CMD + payload + EOF byte count)
//  NUM_CMD      4      legal command IDs 1..NUM_CMD
//  TIMEOUT_CYC  50000  inter-byte timeout in clk cycles (used only with UART_FRAME_TIMEOUT_EN)
// PORTS
//  clk           in   1                    system clock, rising edge
//  rst           in   1                    asynchronous reset, active-low
//  rx_data       in   DATA_W               received byte, qualified by rx_valid
//  rx_valid      in   1                    one-cycle strobe per received byte
//  done_i        in   1                    datapath finished current command (level or pulse)
//  cmd_valid     out  1                    one-cycle pulse: valid frame accepted
//  cmd_id        out  $clog2(NUM_CMD+1)    command ID, stable from cmd_valid until done_i
//  n_load        out  1                    one-cycle pulse with cmd_valid when cmd_id==CMD_SET_N
//  n_value       out  DATA_W               committed N; holds until the next valid SET_N
//  payload_valid out  1                    one-cycle pulse per payload byte accepted
//  payload_data  out  DATA_W               payload byte, valid with payload_valid
//  payload_idx   out  $clog2(MAX_LEN)      index of payload byte, 0-based
//  busy          out  1                    high from cmd_valid until done_i is sampled
//  frame_err     out  1                    one-cycle pulse on any frame rejection
//  err_code      out  3                    cause, valid with frame_err; holds last value
// BEHAVIOUR
//  - Reset: state SOF. All outputs 0, except n_value = 1 (default N).
//  - A byte is consumed only on a cycle with rx_valid=1. All outputs are registered; responses
//    appear on the cycle after the consuming rx_valid.
//  - SOF: byte==0xFE -> LEN. Any other byte is discarded silently.
//  - LEN: 2<=byte<=MAX_LEN -> CMD, latch len. Otherwise ERR_LEN, -> SOF.
//  - CMD: byte in 1..NUM_CMD and len==CMD_LEN[byte] (package table; 0 = any length) -> latch
//    cmd. Then len==2 -> EOF, else -> PAYLOAD. Otherwise ERR_CMD, -> SOF.
//  - PAYLOAD: pulse payload_valid with payload_idx, and increment the count. After len-2 bytes
//    -> EOF.
//    - For CMD_SET_N, byte 0 must satisfy 1<=byte<=MAX_N: held in a shadow register, not yet
//      in n_value. On violation: ERR_ARG, -> SOF.
//  - EOF: byte==0xEF -> cmd_valid pulse; copy shadow to n_value with an n_load pulse (SET_N
//    only); -> EXEC. Otherwise ERR_EOF, -> SOF. The offending byte is not re-evaluated as SOF.
//  - EXEC: busy=1. Any rx_valid in EXEC -> byte dropped, frame_err with ERR_BUSY; state is
//    unchanged. done_i=1 -> SOF, busy falls on the next cycle. done_i is ignored in every
//    other state.
//  - A simultaneous done_i and rx_valid in EXEC: done wins, the byte is dropped, no error.
//  - Payload counter width is $clog2(MAX_LEN); the count never wraps because LEN is range-checked.
//  - A reset deasserted mid-frame restarts cleanly in SOF; partial payload is never committed.
//  - err_code values (from mxv_pkg):
//    - 1 LEN, 2 CMD, 3 ARG, 4 EOF, 5 TIMEOUT, 6 BUSY.
// CONFIGURATION
//  UART_FRAME_TIMEOUT_EN defined:
//  - In LEN/CMD/PAYLOAD/EOF, a cycle counter resets on every rx_valid.
//  - On reaching TIMEOUT_CYC-1 with no byte: frame_err with ERR_TIMEOUT, -> SOF.
//  - EXEC never times out.
//  UART_FRAME_TIMEOUT_EN undefined: no counter is built and the parser waits indefinitely.
// STRUCTURE
//  - mxv_pkg holds:
//    - the SOF/EOF byte constants;
//    - the cmd_e enum: CMD_SET_N=1, CMD_RESEND=2, CMD_RUN=3, CMD_STATUS=4;
//    - the CMD_LEN table: SET_N=3, RESEND=2, others 0;
//    - the err_e enum;
//    - the parser state enum: SOF, LEN, CMD, PAYLOAD, EOF, EXEC.
//  - One sub-module, frame_timeout_ctr: a counter with clear and expire, instantiated only
//    under the macro.
// TESTING
//  - FE 03 01 05 EF -> cmd_valid, cmd_id=1, n_load, n_value=5. One payload_valid with
//    idx 0, data 05. busy stays high until done_i.
//  - FE 02 02 EF -> cmd_valid, cmd_id=2, no n_load, n_value unchanged; done_i -> busy=0,
//    back to SOF.
//  - FE 03 01 09 EF with MAX_N=8 -> frame_err on 09, err_code=3, n_value unchanged. The
//    trailing EF is discarded in SOF.
//  - FE 03 01 05 AA -> err_code=4, no cmd_valid, n_value unchanged. FE 01 -> err_code=1.
//    FE 02 07 -> err_code=2.
//  - Byte during EXEC -> frame_err with err_code=6, busy stays 1. done_i with a byte on the
//    same cycle -> no error, SOF.
//  - With macro, TIMEOUT_CYC=100: FE 03, then idle for 100 cycles -> err_code=5, SOF. Next
//    full frame is accepted.

Source files
------------

// File: rtl/mxv_pkg.sv
// Shared constants, enums and the per-command length table for the MxV UART frame parser.
package mxv_pkg;

  localparam logic [7:0] SOF_BYTE = 8'hFE;
  localparam logic [7:0] EOF_BYTE = 8'hEF;

  typedef enum logic [7:0] {
    CMD_SET_N  = 8'd1,
    CMD_RESEND = 8'd2,
    CMD_RUN    = 8'd3,
    CMD_STATUS = 8'd4
  } cmd_e;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_LEN     = 3'd1,
    ERR_CMD     = 3'd2,
    ERR_ARG     = 3'd3,
    ERR_EOF     = 3'd4,
    ERR_TIMEOUT = 3'd5,
    ERR_BUSY    = 3'd6
  } err_e;

  typedef enum logic [2:0] {
    ST_SOF     = 3'd0,
    ST_LEN     = 3'd1,
    ST_CMD     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_EOF     = 3'd4,
    ST_EXEC    = 3'd5
  } state_e;

  // Required LEN byte per command; 0 means any legal length is accepted.
  function automatic int unsigned cmd_len(input int unsigned id);
    case (id)
      32'd1:   return 32'd3;
      32'd2:   return 32'd2;
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/frame_timeout_ctr.sv
// Inter-byte idle timer: reloads on clear, counts down while idle, flags expiry at terminal count.
module frame_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= LOAD_VAL;
    end else if (i_clear) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = !i_clear && (r_cnt == '0);

endmodule

// File: rtl/uart_cmd_frame_parser.sv
// UART command-frame parser (FE LEN CMD payload EF) for the MxV accelerator.
// Optional inter-byte timeout is built when UART_FRAME_TIMEOUT_EN is defined.
//
// state      | meaning
// ST_SOF     | hunting for 0xFE, other bytes discarded
// ST_LEN     | expecting LEN byte
// ST_CMD     | expecting command ID, checked against length table
// ST_PAYLOAD | streaming payload bytes out
// ST_EOF     | expecting 0xEF, commit on match
// ST_EXEC    | command issued, busy until done
module uart_cmd_frame_parser
  import mxv_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MAX_N       = 8,
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned NUM_CMD     = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [DATA_W-1:0]            i_rx_data,
  input  logic                         i_rx_valid,
  input  logic                         i_done,
  output logic                         o_cmd_valid,
  output logic [$clog2(NUM_CMD+1)-1:0] o_cmd_id,
  output logic                         o_n_load,
  output logic [DATA_W-1:0]            o_n_value,
  output logic                         o_payload_valid,
  output logic [DATA_W-1:0]            o_payload_data,
  output logic [$clog2(MAX_LEN)-1:0]   o_payload_idx,
  output logic                         o_busy,
  output logic                         o_frame_err,
  output logic [2:0]                   o_err_code
);

  localparam int unsigned ID_W  = $clog2(NUM_CMD + 1);
  localparam int unsigned IDX_W = $clog2(MAX_LEN);
  localparam logic [ID_W-1:0] ID_SET_N = ID_W'(CMD_SET_N);

  state_e              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_len, w_len_nxt;
  logic [ID_W-1:0]     r_cmd, w_cmd_nxt;
  logic [IDX_W-1:0]    r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]   r_shadow_n, w_shadow_nxt;
  logic                r_cmd_valid, w_cmd_valid_nxt;
  logic [ID_W-1:0]     r_cmd_id, w_cmd_id_nxt;
  logic                r_n_load, w_n_load_nxt;
  logic [DATA_W-1:0]   r_n_value, w_n_value_nxt;
  logic                r_pv, w_pv_nxt;
  logic [DATA_W-1:0]   r_pd, w_pd_nxt;
  logic [IDX_W-1:0]    r_pidx, w_pidx_nxt;
  logic                r_ferr, w_ferr_nxt;
  err_e                r_err, w_err_nxt;

  logic                w_expire;
  int unsigned         w_req_len;
  logic                w_len_ok, w_cmd_ok, w_arg_bad, w_last_pl;

  assign w_req_len = cmd_len(32'(i_rx_data));
  assign w_len_ok  = (i_rx_data >= DATA_W'(2)) && (i_rx_data <= DATA_W'(MAX_LEN));
  assign w_cmd_ok  = (i_rx_data >= DATA_W'(1)) && (i_rx_data <= DATA_W'(NUM_CMD)) &&
                     ((w_req_len == 32'd0) || (w_req_len == 32'(r_len)));
  assign w_arg_bad = (r_cmd == ID_SET_N) && (r_cnt == '0) &&
                     ((i_rx_data < DATA_W'(1)) || (i_rx_data > DATA_W'(MAX_N)));
  assign w_last_pl = (DATA_W'(r_cnt) + DATA_W'(1)) == (r_len - DATA_W'(2));

`ifdef UART_FRAME_TIMEOUT_EN
  logic w_in_frame;
  assign w_in_frame = (r_state == ST_LEN) || (r_state == ST_CMD) ||
                      (r_state == ST_PAYLOAD) || (r_state == ST_EOF);

  frame_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (i_rx_valid || !w_in_frame),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_cmd_nxt       = r_cmd;
    w_cnt_nxt       = r_cnt;
    w_shadow_nxt    = r_shadow_n;
    w_cmd_valid_nxt = 1'b0;
    w_cmd_id_nxt    = r_cmd_id;
    w_n_load_nxt    = 1'b0;
    w_n_value_nxt   = r_n_value;
    w_pv_nxt        = 1'b0;
    w_pd_nxt        = r_pd;
    w_pidx_nxt      = r_pidx;
    w_ferr_nxt      = 1'b0;
    w_err_nxt       = r_err;
    case (r_state)
      ST_SOF: begin
        if (i_rx_valid && (i_rx_data == DATA_W'(SOF_BYTE))) w_state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (i_rx_valid) begin
          if (w_len_ok) begin
            w_len_nxt   = i_rx_data;
            w_state_nxt = ST_CMD;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_err_nxt   = ERR_LEN;
            w_state_nxt = ST_SOF;
          end
        end
      end
      ST_CMD: begin
        if (i_rx_valid) begin
          if (w_cmd_ok) begin
            w_cmd_nxt   = ID_W'(i_rx_data);
            w_cnt_nxt   = '0;
            w_state_nxt = (r_len == DATA_W'(2)) ? ST_EOF : ST_PAYLOAD;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_err_nxt   = ERR_CMD;
            w_state_nxt = ST_SOF;
          end
        end
      end
      ST_PAYLOAD: begin
        if (i_rx_valid) begin
          if (w_arg_bad) begin
            w_ferr_nxt  = 1'b1;
            w_err_nxt   = ERR_ARG;
            w_state_nxt = ST_SOF;
          end else begin
            w_pv_nxt   = 1'b1;
            w_pd_nxt   = i_rx_data;
            w_pidx_nxt = r_cnt;
            w_cnt_nxt  = r_cnt + IDX_W'(1);
            if ((r_cmd == ID_SET_N) && (r_cnt == '0)) w_shadow_nxt = i_rx_data;
            if (w_last_pl) w_state_nxt = ST_EOF;
          end
        end
      end
      ST_EOF: begin
        if (i_rx_valid) begin
          if (i_rx_data == DATA_W'(EOF_BYTE)) begin
            w_cmd_valid_nxt = 1'b1;
            w_cmd_id_nxt    = r_cmd;
            if (r_cmd == ID_SET_N) begin
              w_n_load_nxt  = 1'b1;
              w_n_value_nxt = r_shadow_n;
            end
            w_state_nxt = ST_EXEC;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_err_nxt   = ERR_EOF;
            w_state_nxt = ST_SOF;
          end
        end
      end
      ST_EXEC: begin
        // done takes priority; a byte arriving with done is dropped silently
        if (i_done) begin
          w_state_nxt = ST_SOF;
        end else if (i_rx_valid) begin
          w_ferr_nxt = 1'b1;
          w_err_nxt  = ERR_BUSY;
        end
      end
      default: w_state_nxt = ST_SOF;
    endcase
    if (w_expire) begin
      w_ferr_nxt  = 1'b1;
      w_err_nxt   = ERR_TIMEOUT;
      w_state_nxt = ST_SOF;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_SOF;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len       <= '0;
      r_cmd       <= '0;
      r_cnt       <= '0;
      r_shadow_n  <= DATA_W'(1);
      r_cmd_valid <= 1'b0;
      r_cmd_id    <= '0;
      r_n_load    <= 1'b0;
      r_n_value   <= DATA_W'(1);
      r_pv        <= 1'b0;
      r_pd        <= '0;
      r_pidx      <= '0;
      r_ferr      <= 1'b0;
      r_err       <= ERR_NONE;
    end else begin
      r_len       <= w_len_nxt;
      r_cmd       <= w_cmd_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shadow_n  <= w_shadow_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_cmd_id    <= w_cmd_id_nxt;
      r_n_load    <= w_n_load_nxt;
      r_n_value   <= w_n_value_nxt;
      r_pv        <= w_pv_nxt;
      r_pd        <= w_pd_nxt;
      r_pidx      <= w_pidx_nxt;
      r_ferr      <= w_ferr_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign o_cmd_valid     = r_cmd_valid;
  assign o_cmd_id        = r_cmd_id;
  assign o_n_load        = r_n_load;
  assign o_n_value       = r_n_value;
  assign o_payload_valid = r_pv;
  assign o_payload_data  = r_pd;
  assign o_payload_idx   = r_pidx;
  assign o_busy          = (r_state == ST_EXEC);
  assign o_frame_err     = r_ferr;
  assign o_err_code      = r_err;

endmodule

// File: tb/tb_uart_cmd_frame_parser.sv
// Directed bench for uart_cmd_frame_parser; timeout cases run when UART_FRAME_TIMEOUT_EN is defined.
module tb_uart_cmd_frame_parser;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TB_TMO = 100;
`else
  localparam int TB_TMO = 50000;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       done = 1'b0;
  logic       cmd_valid, n_load, payload_valid, busy, frame_err;
  logic [2:0] cmd_id, err_code;
  logic [7:0] n_value, payload_data;
  logic [3:0] payload_idx;

  int n_checks = 0;
  int n_fail   = 0;

  uart_cmd_frame_parser #(
    .DATA_W      (8),
    .MAX_N       (8),
    .MAX_LEN     (16),
    .NUM_CMD     (4),
    .TIMEOUT_CYC (TB_TMO)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_rx_data       (rx_data),
    .i_rx_valid      (rx_valid),
    .i_done          (done),
    .o_cmd_valid     (cmd_valid),
    .o_cmd_id        (cmd_id),
    .o_n_load        (n_load),
    .o_n_value       (n_value),
    .o_payload_valid (payload_valid),
    .o_payload_data  (payload_data),
    .o_payload_idx   (payload_idx),
    .o_busy          (busy),
    .o_frame_err     (frame_err),
    .o_err_code      (err_code)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one byte for one cycle; returns at the negedge after it was consumed.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_valid", cmd_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_n_value", n_value, 1);
    check_eq("rst_err_code", err_code, 0);
    check_eq("rst_frame_err", frame_err, 0);
    check_eq("rst_pv", payload_valid, 0);
    rst_n = 1'b1;

    // SET_N 5
    send_byte(8'hFE); send_byte(8'h03); send_byte(8'h01);
    send_byte(8'h05);
    check_eq("setn_pv", payload_valid, 1);
    check_eq("setn_pidx", payload_idx, 0);
    check_eq("setn_pdata", payload_data, 8'h05);
    check_eq("setn_shadow_not_yet", n_value, 1);
    send_byte(8'hEF);
    check_eq("setn_cmd_valid", cmd_valid, 1);
    check_eq("setn_cmd_id", cmd_id, 1);
    check_eq("setn_n_load", n_load, 1);
    check_eq("setn_n_value", n_value, 5);
    check_eq("setn_busy", busy, 1);
    repeat (5) @(negedge clk);
    check_eq("setn_busy_hold", busy, 1);
    check_eq("setn_cv_pulse", cmd_valid, 0);
    check_eq("setn_cmd_id_hold", cmd_id, 1);
    pulse_done();
    check_eq("setn_busy_clr", busy, 0);

    // RESEND
    send_byte(8'hFE); send_byte(8'h02); send_byte(8'h02); send_byte(8'hEF);
    check_eq("resend_cv", cmd_valid, 1);
    check_eq("resend_id", cmd_id, 2);
    check_eq("resend_no_nload", n_load, 0);
    check_eq("resend_n_value", n_value, 5);
    pulse_done();
    check_eq("resend_busy_clr", busy, 0);

    // SET_N argument above MAX_N
    send_byte(8'hFE); send_byte(8'h03); send_byte(8'h01); send_byte(8'h09);
    check_eq("arg_ferr", frame_err, 1);
    check_eq("arg_code", err_code, 3);
    check_eq("arg_no_pv", payload_valid, 0);
    send_byte(8'hEF);
    check_eq("arg_ef_ferr", frame_err, 0);
    check_eq("arg_ef_cv", cmd_valid, 0);
    check_eq("arg_n_value", n_value, 5);

    // bad EOF
    send_byte(8'hFE); send_byte(8'h03); send_byte(8'h01); send_byte(8'h05); send_byte(8'hAA);
    check_eq("eof_ferr", frame_err, 1);
    check_eq("eof_code", err_code, 4);
    check_eq("eof_cv", cmd_valid, 0);
    check_eq("eof_n_value", n_value, 5);
    check_eq("eof_busy", busy, 0);

    send_byte(8'hFE); send_byte(8'h01);
    check_eq("len_low_code", err_code, 1);
    check_eq("len_low_ferr", frame_err, 1);
    send_byte(8'hFE); send_byte(8'h11);
    check_eq("len_high_code", err_code, 1);
    send_byte(8'hFE); send_byte(8'h02); send_byte(8'h07);
    check_eq("cmd_id_code", err_code, 2);
    send_byte(8'hFE); send_byte(8'h03); send_byte(8'h02);
    check_eq("cmd_len_code", err_code, 2);
    send_byte(8'hFE); send_byte(8'h03); send_byte(8'h01); send_byte(8'h00);
    check_eq("arg_zero_code", err_code, 3);
    check_eq("arg_zero_ferr", frame_err, 1);

    // SET_N at MAX_N boundary
    send_byte(8'hFE); send_byte(8'h03); send_byte(8'h01); send_byte(8'h08); send_byte(8'hEF);
    check_eq("maxn_cv", cmd_valid, 1);
    check_eq("maxn_n_value", n_value, 8);
    pulse_done();

    // RUN with two payload bytes
    send_byte(8'hFE); send_byte(8'h04); send_byte(8'h03);
    send_byte(8'hAA);
    check_eq("run_pv0", payload_valid, 1);
    check_eq("run_idx0", payload_idx, 0);
    check_eq("run_d0", payload_data, 8'hAA);
    send_byte(8'hBB);
    check_eq("run_idx1", payload_idx, 1);
    check_eq("run_d1", payload_data, 8'hBB);
    check_eq("run_no_cv_yet", cmd_valid, 0);
    send_byte(8'hEF);
    check_eq("run_cv", cmd_valid, 1);
    check_eq("run_id", cmd_id, 3);
    check_eq("run_no_nload", n_load, 0);
    check_eq("run_n_value", n_value, 8);

    // byte while busy, then done with simultaneous byte
    send_byte(8'h55);
    check_eq("busy_ferr", frame_err, 1);
    check_eq("busy_code", err_code, 6);
    check_eq("busy_hold", busy, 1);
    @(negedge clk);
    done = 1'b1; rx_valid = 1'b1; rx_data = 8'hFE;
    @(negedge clk);
    done = 1'b0; rx_valid = 1'b0;
    check_eq("done_rx_ferr", frame_err, 0);
    check_eq("done_rx_busy", busy, 0);
    check_eq("done_rx_code_hold", err_code, 6);

    send_byte(8'hFE); send_byte(8'h02); send_byte(8'h04); send_byte(8'hEF);
    check_eq("status_cv", cmd_valid, 1);
    check_eq("status_id", cmd_id, 4);
    pulse_done();

    // reset mid-frame
    send_byte(8'hFE); send_byte(8'h03); send_byte(8'h01);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_n_value", n_value, 1);
    check_eq("midrst_busy", busy, 0);
    rst_n = 1'b1;
    send_byte(8'h04);
    check_eq("midrst_no_pv", payload_valid, 0);
    send_byte(8'hFE); send_byte(8'h03); send_byte(8'h01); send_byte(8'h04); send_byte(8'hEF);
    check_eq("midrst_cv", cmd_valid, 1);
    check_eq("midrst_n_new", n_value, 4);
    pulse_done();

`ifdef UART_FRAME_TIMEOUT_EN
    begin
      int seen;
      seen = 0;
      send_byte(8'hFE); send_byte(8'h03);
      for (int i = 1; i <= 150; i++) begin
        @(negedge clk);
        if (frame_err) begin
          seen = i;
          break;
        end
      end
      check_eq("tmo_cycles", seen, 100);
      check_eq("tmo_code", err_code, 5);
      send_byte(8'hFE); send_byte(8'h03); send_byte(8'h01); send_byte(8'h06); send_byte(8'hEF);
      check_eq("tmo_next_cv", cmd_valid, 1);
      check_eq("tmo_next_n", n_value, 6);
      repeat (120) @(negedge clk);
      check_eq("tmo_exec_no_err", frame_err, 0);
      check_eq("tmo_exec_busy", busy, 1);
      pulse_done();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
